// File: rtl/hazard_stall_unit_pkg.sv
// Shared types for the hazard stall/flush controller.
// State encoding and the hard-wired zero register address.
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hsu_state_e;

  localparam int unsigned X0 = 0;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             inc,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: load-use, taken-branch flush and
// data-memory wait freeze with timeout watchdog and counters.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int AddressSize  = 5,
  parameter int CounterWidth = 16,
  parameter int MemTimeout   = 64
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [AddressSize-1:0]  Rs1ID,
  input  logic [AddressSize-1:0]  Rs2ID,
  input  logic                    useRs1ID,
  input  logic                    useRs2ID,
  input  logic [AddressSize-1:0]  EXRegisterRd,
  input  logic                    memReadEX,
  input  logic                    branchTakenEX,
  input  logic                    memReqMem,
  input  logic                    memReadyMem,
  output logic                    pcWrite,
  output logic                    ifidWrite,
  output logic                    ifidFlush,
  output logic                    idexWrite,
  output logic                    idexBubble,
  output logic                    exmemWrite,
  output logic                    memwbBubble,
  output logic                    memError,
  output logic [CounterWidth-1:0] stallCycles,
  output logic [CounterWidth-1:0] flushCount
);

  localparam int WaitW = $clog2(MemTimeout);
  localparam logic [WaitW-1:0] WaitLast =
    WaitW'(MemTimeout - 1);

  hsu_state_e       state;
  logic [WaitW-1:0] waitCnt;
  logic             loadUse;
  logic             memWait;
  logic             stallInc;
  logic             flushInc;

  assign memWait = memReqMem && !memReadyMem;

  assign loadUse = memReadEX
    && (EXRegisterRd != AddressSize'(X0))
    && ((useRs1ID && (Rs1ID == EXRegisterRd))
     || (useRs2ID && (Rs2ID == EXRegisterRd)));

  always_comb begin
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    ifidFlush   = 1'b0;
    idexWrite   = 1'b1;
    idexBubble  = 1'b0;
    exmemWrite  = 1'b1;
    memwbBubble = 1'b0;
    stallInc    = 1'b0;
    flushInc    = 1'b0;
    unique case (state)
      RUN: begin
        if (memWait) begin
          pcWrite     = 1'b0;
          ifidWrite   = 1'b0;
          idexWrite   = 1'b0;
          exmemWrite  = 1'b0;
          memwbBubble = 1'b1;
        end else if (branchTakenEX) begin
          ifidFlush  = 1'b1;
          idexBubble = 1'b1;
          flushInc   = 1'b1;
        end else if (loadUse) begin
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          idexBubble = 1'b1;
          stallInc   = 1'b1;
        end
      end
      MEM_WAIT: begin
        stallInc = 1'b1;
        // The ready cycle releases the pipeline immediately.
        if (!memReadyMem) begin
          pcWrite     = 1'b0;
          ifidWrite   = 1'b0;
          idexWrite   = 1'b0;
          exmemWrite  = 1'b0;
          memwbBubble = 1'b1;
        end
      end
      default: begin
        pcWrite     = 1'b0;
        ifidWrite   = 1'b0;
        idexWrite   = 1'b0;
        exmemWrite  = 1'b0;
        memwbBubble = 1'b1;
      end
    endcase
    if (arst) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      ifidFlush   = 1'b0;
      idexWrite   = 1'b0;
      idexBubble  = 1'b0;
      exmemWrite  = 1'b0;
      memwbBubble = 1'b0;
      stallInc    = 1'b0;
      flushInc    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= RUN;
      waitCnt  <= '0;
      memError <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (memWait) begin
            state   <= MEM_WAIT;
            waitCnt <= WaitW'(1);
          end
        end
        MEM_WAIT: begin
          if (memReadyMem) begin
            state   <= RUN;
            waitCnt <= '0;
          end else if (waitCnt == WaitLast) begin
            state    <= ERROR;
            memError <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WaitW'(1);
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= ERROR;
        end
      endcase
    end
  end

  sat_counter #(.Width(CounterWidth)) u_stall (
    .clk   (clk),
    .arst  (arst),
    .inc   (stallInc),
    .count (stallCycles)
  );

  sat_counter #(.Width(CounterWidth)) u_flush (
    .clk   (clk),
    .arst  (arst),
    .inc   (flushInc),
    .count (flushCount)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed cases then
// random traffic checked against a cycle-level reference model.
module tb_hazard_stall_unit;

  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int MT   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [6:0]    ctrl;
    logic          err;
    logic [CW-1:0] st;
    logic [CW-1:0] fl;
    string         tag;
  } exp_t;

  logic          clk = 0;
  logic          arst = 1;
  logic [AW-1:0] Rs1ID = 0, Rs2ID = 0, EXRegisterRd = 0;
  logic          useRs1ID = 0, useRs2ID = 0;
  logic          memReadEX = 0, branchTakenEX = 0;
  logic          memReqMem = 0, memReadyMem = 0;
  logic          pcWrite, ifidWrite, ifidFlush, idexWrite;
  logic          idexBubble, exmemWrite, memwbBubble, memError;
  logic [CW-1:0] stallCycles, flushCount;

  hazard_stall_unit #(
    .AddressSize (AW),
    .CounterWidth(CW),
    .MemTimeout  (MT)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .Rs1ID        (Rs1ID),
    .Rs2ID        (Rs2ID),
    .useRs1ID     (useRs1ID),
    .useRs2ID     (useRs2ID),
    .EXRegisterRd (EXRegisterRd),
    .memReadEX    (memReadEX),
    .branchTakenEX(branchTakenEX),
    .memReqMem    (memReqMem),
    .memReadyMem  (memReadyMem),
    .pcWrite      (pcWrite),
    .ifidWrite    (ifidWrite),
    .ifidFlush    (ifidFlush),
    .idexWrite    (idexWrite),
    .idexBubble   (idexBubble),
    .exmemWrite   (exmemWrite),
    .memwbBubble  (memwbBubble),
    .memError     (memError),
    .stallCycles  (stallCycles),
    .flushCount   (flushCount)
  );

  always #5 clk = ~clk;

  // {pc, ifidW, ifidF, idexW, idexB, exmemW, memwbB}
  localparam logic [6:0] P_RUN    = 7'b1101010;
  localparam logic [6:0] P_FREEZE = 7'b0000001;
  localparam logic [6:0] P_BRANCH = 7'b1111110;
  localparam logic [6:0] P_LOADU  = 7'b0001110;

  exp_t q[$];
  int   ncmp = 0;
  int   nfail = 0;

  // Reference model: how long the current access has waited,
  // whether the watchdog fired, and the two event counts.
  int m_wait = 0;
  bit m_err  = 0;
  int m_st   = 0;
  int m_fl   = 0;

  task automatic model_push(input string tag);
    exp_t e;
    bit   lu;
    e.tag = tag;
    if (arst) begin
      m_wait = 0; m_err = 0; m_st = 0; m_fl = 0;
      e.ctrl = 7'b0; e.err = 0; e.st = 0; e.fl = 0;
      q.push_back(e);
      return;
    end
    e.err = m_err;
    e.st  = CW'(m_st);
    e.fl  = CW'(m_fl);
    lu = memReadEX && EXRegisterRd != 0 &&
         ((useRs1ID && Rs1ID == EXRegisterRd) ||
          (useRs2ID && Rs2ID == EXRegisterRd));
    if (m_err) begin
      e.ctrl = P_FREEZE;
    end else if (m_wait > 0) begin
      m_st++;
      if (memReadyMem) begin
        e.ctrl = P_RUN;
        m_wait = 0;
      end else begin
        e.ctrl = P_FREEZE;
        m_wait++;
        if (m_wait >= MT) m_err = 1;
      end
    end else if (memReqMem && !memReadyMem) begin
      e.ctrl = P_FREEZE;
      m_wait = 1;
    end else if (branchTakenEX) begin
      e.ctrl = P_BRANCH;
      m_fl++;
    end else if (lu) begin
      e.ctrl = P_LOADU;
      m_st++;
    end else begin
      e.ctrl = P_RUN;
    end
    if (m_st > CMAX) m_st = CMAX;
    if (m_fl > CMAX) m_fl = CMAX;
    q.push_back(e);
  endtask

  task automatic cyc(
    input string tag, input bit r,
    input int rs1, input int rs2, input bit u1, input bit u2,
    input int rd, input bit mr, input bit br,
    input bit mq, input bit my);
    arst = r;
    Rs1ID = AW'(rs1); Rs2ID = AW'(rs2);
    useRs1ID = u1; useRs2ID = u2;
    EXRegisterRd = AW'(rd);
    memReadEX = mr; branchTakenEX = br;
    memReqMem = mq; memReadyMem = my;
    model_push(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: DUT outputs are sampled mid-cycle, away from edges.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = q.pop_front();
      act = {pcWrite, ifidWrite, ifidFlush, idexWrite,
             idexBubble, exmemWrite, memwbBubble};
      ncmp++;
      if (act !== e.ctrl) begin
        nfail++;
        $display("FAIL %s ctrl: got %b want %b",
                 e.tag, act, e.ctrl);
      end
      ncmp++;
      if (memError !== e.err) begin
        nfail++;
        $display("FAIL %s memError: got %b want %b",
                 e.tag, memError, e.err);
      end
      ncmp++;
      if (stallCycles !== e.st) begin
        nfail++;
        $display("FAIL %s stallCycles: got %0d want %0d",
                 e.tag, stallCycles, e.st);
      end
      ncmp++;
      if (flushCount !== e.fl) begin
        nfail++;
        $display("FAIL %s flushCount: got %0d want %0d",
                 e.tag, flushCount, e.fl);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("reset", 1, 5, 5, 1, 1, 5, 1, 1, 1, 0);
    idle("idle");
    cyc("loaduse", 0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
    cyc("after_lu", 0, 5, 0, 1, 0, 5, 0, 0, 0, 0);
    cyc("x0", 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    cyc("no_use2", 0, 1, 5, 0, 0, 5, 1, 0, 0, 0);
    cyc("rs2_lu", 0, 1, 7, 0, 1, 7, 1, 0, 0, 0);
    cyc("br_vs_lu", 0, 5, 0, 1, 0, 5, 1, 1, 0, 0);
    idle("idle");
    cyc("ready_no_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc("memwait", 0, 5, 0, 1, 0, 5, 1, 1, 1, 0);
    cyc("mem_ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle("back_run");
    for (int i = 0; i < 6; i++)
      cyc("timeout", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("err_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("err_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("post_err");
    cyc("mid_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mid_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("wait_reset", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle("post_wreset");
    for (int i = 0; i < 20; i++)
      cyc("saturate", 0, 3, 0, 1, 0, 3, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc("br_sat", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("rnd_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, mq, my;
      r  = ($urandom_range(0, 149) == 0);
      mq = ($urandom_range(0, 3) == 0);
      my = ($urandom_range(0, 2) != 0);
      cyc("random", r,
          $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom), 1'($urandom),
          $urandom_range(0, 3), 1'($urandom),
          ($urandom_range(0, 4) == 0), mq, my);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    #2;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline stall/flush controller for the 5-stage RISC-V core; counterpart of the EX-stage forwarding logic.
- Handles hazards forwarding cannot resolve: load-use, taken-branch flush, and multi-cycle data-memory waits.
- Drives the PC and pipeline-register write enables and bubble inserts. Keeps a wait-timeout watchdog and saturating performance counters.

Parameters:
AddressSize, 5, register address width
CounterWidth, 16, width of the performance counters
MemTimeout, 64, max MEM_WAIT cycles before error (>=2)

Ports:
clk  in  1  clock, rising edge
arst  in  1  asynchronous active-high reset
Rs1ID  in  AddressSize  rs1 of instruction in ID
Rs2ID  in  AddressSize  rs2 of instruction in ID
useRs1ID  in  1  ID instruction reads rs1
useRs2ID  in  1  ID instruction reads rs2
EXRegisterRd  in  AddressSize  rd of instruction in EX
memReadEX  in  1  EX instruction is a load
branchTakenEX  in  1  branch/jump resolved taken in EX
memReqMem  in  1  MEM instruction accesses data memory
memReadyMem  in  1  data memory completes access this cycle
pcWrite  out  1  PC update enable
ifidWrite  out  1  IF/ID write enable
ifidFlush  out  1  IF/ID load NOP
idexWrite  out  1  ID/EX write enable
idexBubble  out  1  ID/EX load NOP
exmemWrite  out  1  EX/MEM write enable
memwbBubble  out  1  MEM/WB load NOP
memError  out  1  sticky memory-timeout flag
stallCycles  out  CounterWidth  saturating count of load-use plus MEM_WAIT cycles
flushCount  out  CounterWidth  saturating count of branch flushes

Behaviour:
- Reset: arst high forces state RUN, waitCnt=0, memError=0, stallCycles=0, flushCount=0.
  - All write enables, flush and bubble outputs are 0 while arst is high (gated combinationally).
- Control outputs are combinational (Mealy) from state and inputs, valid in the same cycle. Counters and state update on posedge clk.
- Default in RUN with no hazard: all *Write=1, all flush/bubble=0.
- loadUse = memReadEX && EXRegisterRd!=0 && ((useRs1ID && Rs1ID==EXRegisterRd) || (useRs2ID && Rs2ID==EXRegisterRd)).
  - Register x0 never creates a hazard.
- memWait = memReqMem && !memReadyMem.
- FSM states: RUN, MEM_WAIT, ERROR. Priority within RUN: memWait > branchTakenEX > loadUse.
- RUN, memWait: output the freeze pattern this cycle.
  - Freeze pattern: pcWrite=ifidWrite=idexWrite=exmemWrite=0, memwbBubble=1.
  - Next state MEM_WAIT, waitCnt<=1.
- RUN, branchTakenEX (no memWait): ifidFlush=1, idexBubble=1, PC written. Branch outranks loadUse (the ID instruction is discarded anyway). flushCount++.
- RUN, loadUse only: pcWrite=0, ifidWrite=0, idexBubble=1, exmemWrite=1. Exactly one bubble per load, because the load advances to MEM next cycle. stallCycles++.
- MEM_WAIT: freeze pattern each cycle, stallCycles++.
  - memReadyMem=1: return to RUN with default outputs this cycle so the pipeline advances; waitCnt<=0.
  - Otherwise waitCnt++. When waitCnt==MemTimeout-1 without ready: next state ERROR, memError<=1.
  - branchTakenEX and loadUse are ignored while frozen. The inputs are held by the frozen pipeline and are re-evaluated in RUN.
- ERROR: permanent freeze pattern, memError=1. Only arst exits.
- Counters saturate at all-ones and never wrap. Both count in the same cycle when applicable.
- memReadyMem in RUN without memReqMem is ignored.
- Reset mid-MEM_WAIT: returns to RUN immediately (asynchronous). waitCnt and counters clear.

Decomposition:
- Shared package: state encoding constants (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2) and the x0 address constant.
- One natural sub-module, sat_counter (parameterised width, inc, arst, clk), instantiated twice for stallCycles and flushCount.

Test Plan:
- Load-use: memReadEX=1, EXRegisterRd=5, Rs1ID=5, useRs1ID=1 -> one cycle pcWrite=0, ifidWrite=0, idexBubble=1; stallCycles 0->1; next cycle (memReadEX=0) default outputs.
- x0/no-use: EXRegisterRd=0, Rs1ID=0, memReadEX=1 -> no stall. Rs2ID=5 with useRs2ID=0 and EXRegisterRd=5 -> no stall.
- Branch vs load-use same cycle: branchTakenEX=1 plus loadUse true -> ifidFlush=1, idexBubble=1, pcWrite=1; flushCount=1, stallCycles unchanged.
- Memory wait: memReqMem=1, memReadyMem=0 for 3 cycles, then 1 -> freeze pattern for 3 cycles, default in the ready cycle; stallCycles=3; state back to RUN.
- Timeout: MemTimeout=4, memReadyMem held 0 -> memError=1 after the 4th wait cycle, freeze persists; asserting arst mid-ERROR clears memError and counters and returns to RUN.
- Saturation: CounterWidth=4, 20 consecutive load-use stalls -> stallCycles stops at 15.
